// File: rtl/rob_buffer.sv
// rob_buffer: parametrised reorder buffer (circular queue of ROB entries).
//   Allocates one entry per cycle at the tail, accepts completions from
//   WB_PORTS writeback ports by ROB index, and retires up to RETIRE_W
//   consecutive completed entries per cycle from the head.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   flush                      pipeline flush (only when ROB_FLUSH_EN is defined)
//   alloc_valid/ready/idx      dispatch handshake, granted index = tail
//   alloc_opcode/old/curr_preg allocated entry payload
//   wb_valid/idx/value/rs2     per-port completion (packed, port 0 in LSBs)
//   retire_en                  commit stage accepts retirements
//   retire_valid + payloads    per-slot retirement (thermometer, slot 0 first)
//   count, empty               occupancy
// Optional feature macro: ROB_FLUSH_EN (adds the flush port).
module rob_buffer #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PREG_W   = 6,
  parameter int unsigned OPC_W    = 7,
  parameter int unsigned WB_PORTS = 2,
  parameter int unsigned RETIRE_W = 2,
  localparam int unsigned IDX_W   = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef ROB_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [OPC_W-1:0]             alloc_opcode,
  input  logic [PREG_W-1:0]            alloc_old_preg,
  input  logic [PREG_W-1:0]            alloc_curr_preg,
  output logic [IDX_W-1:0]             alloc_idx,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]    wb_idx,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_value,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_rs2_value,
  input  logic                         retire_en,
  output logic [RETIRE_W-1:0]          retire_valid,
  output logic [RETIRE_W*PREG_W-1:0]   retire_old_preg,
  output logic [RETIRE_W*PREG_W-1:0]   retire_curr_preg,
  output logic [RETIRE_W*OPC_W-1:0]    retire_opcode,
  output logic [RETIRE_W*DATA_W-1:0]   retire_value,
  output logic [RETIRE_W*DATA_W-1:0]   retire_rs2_value,
  output logic [IDX_W:0]               count,
  output logic                         empty
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]  in_use_q, in_use_d;
  logic [DEPTH-1:0]  complete_q, complete_d;
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [OPC_W-1:0]  opcode_q   [DEPTH];
  logic [OPC_W-1:0]  opcode_d   [DEPTH];
  logic [PREG_W-1:0] old_preg_q [DEPTH];
  logic [PREG_W-1:0] old_preg_d [DEPTH];
  logic [PREG_W-1:0] curr_preg_q[DEPTH];
  logic [PREG_W-1:0] curr_preg_d[DEPTH];
  logic [DATA_W-1:0] value_q    [DEPTH];
  logic [DATA_W-1:0] value_d    [DEPTH];
  logic [DATA_W-1:0] rs2_q      [DEPTH];
  logic [DATA_W-1:0] rs2_d      [DEPTH];

  logic              flush_w;
  logic              alloc_fire;
  logic              chain;
  logic [IDX_W-1:0]  ret_slot;
  logic [IDX_W-1:0]  clr_slot;
  logic [IDX_W-1:0]  wb_slot;
  logic [IDX_W-1:0]  pl_slot;
  logic [CNT_W-1:0]  n_ret;

`ifdef ROB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Fullness comes from the registered count only, so a slot freed by a
  // retire this cycle is not reusable until the next one.
  assign alloc_ready = (count_q != CNT_W'(DEPTH));
  assign alloc_fire  = alloc_valid & alloc_ready & ~flush_w;
  assign alloc_idx   = tail_q;
  assign count       = count_q;
  assign empty       = (count_q == '0);

  // Retire window: the AND chain stops at the first entry that is not both
  // in use and complete, which keeps retire_valid contiguous from bit 0.
  always_comb begin
    retire_valid     = '0;
    retire_old_preg  = '0;
    retire_curr_preg = '0;
    retire_opcode    = '0;
    retire_value     = '0;
    retire_rs2_value = '0;
    n_ret            = '0;
    ret_slot         = '0;
    chain            = retire_en & ~flush_w;
    for (int unsigned k = 0; k < RETIRE_W; k++) begin
      ret_slot = head_q + IDX_W'(k);
      chain    = chain & in_use_q[ret_slot] & complete_q[ret_slot];
      retire_valid[k]                         = chain;
      retire_old_preg [k*PREG_W +: PREG_W]    = old_preg_q[ret_slot];
      retire_curr_preg[k*PREG_W +: PREG_W]    = curr_preg_q[ret_slot];
      retire_opcode   [k*OPC_W  +: OPC_W]     = opcode_q[ret_slot];
      retire_value    [k*DATA_W +: DATA_W]    = value_q[ret_slot];
      retire_rs2_value[k*DATA_W +: DATA_W]    = rs2_q[ret_slot];
      if (chain) n_ret = n_ret + CNT_W'(1);
    end
  end

  // Control state: writeback may mark a retiring entry complete, but the
  // retire clear is applied last so the entry still leaves the buffer.
  always_comb begin
    in_use_d   = in_use_q;
    complete_d = complete_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    wb_slot    = '0;
    clr_slot   = '0;
    if (flush_w) begin
      in_use_d   = '0;
      complete_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (alloc_fire) begin
        in_use_d[tail_q]   = 1'b1;
        complete_d[tail_q] = 1'b0;
        tail_d             = tail_q + IDX_W'(1);
      end
      for (int unsigned p = 0; p < WB_PORTS; p++) begin
        wb_slot = wb_idx[p*IDX_W +: IDX_W];
        if (wb_valid[p] && in_use_q[wb_slot]) complete_d[wb_slot] = 1'b1;
      end
      for (int unsigned k = 0; k < RETIRE_W; k++) begin
        clr_slot = head_q + IDX_W'(k);
        if (retire_valid[k]) begin
          in_use_d[clr_slot]   = 1'b0;
          complete_d[clr_slot] = 1'b0;
        end
      end
      head_d  = head_q + n_ret[IDX_W-1:0];
      count_d = count_q + CNT_W'(alloc_fire) - n_ret;
    end
  end

  // Payload: higher port numbers are applied later and therefore win.
  always_comb begin
    opcode_d    = opcode_q;
    old_preg_d  = old_preg_q;
    curr_preg_d = curr_preg_q;
    value_d     = value_q;
    rs2_d       = rs2_q;
    pl_slot     = '0;
    if (alloc_fire) begin
      opcode_d[tail_q]    = alloc_opcode;
      old_preg_d[tail_q]  = alloc_old_preg;
      curr_preg_d[tail_q] = alloc_curr_preg;
    end
    for (int unsigned p = 0; p < WB_PORTS; p++) begin
      pl_slot = wb_idx[p*IDX_W +: IDX_W];
      if (wb_valid[p] && in_use_q[pl_slot]) begin
        value_d[pl_slot] = wb_value[p*DATA_W +: DATA_W];
        rs2_d[pl_slot]   = wb_rs2_value[p*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_use_q   <= '0;
      complete_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      in_use_q   <= in_use_d;
      complete_q <= complete_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    opcode_q    <= opcode_d;
    old_preg_q  <= old_preg_d;
    curr_preg_q <= curr_preg_d;
    value_q     <= value_d;
    rs2_q       <= rs2_d;
  end

endmodule

// File: tb/tb_rob_buffer.sv
// tb_rob_buffer: directed and randomized bench for rob_buffer against an
// in-order queue reference model. Define ROB_FLUSH_EN to include flush.
module tb_rob_buffer;

  localparam int unsigned DEPTH    = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned PREG_W   = 6;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned WB_PORTS = 2;
  localparam int unsigned RETIRE_W = 2;
  localparam int unsigned IDX_W    = 5;

  logic                        clk;
  logic                        rst_n;
  logic                        flush;
  logic                        alloc_valid;
  logic                        alloc_ready;
  logic [OPC_W-1:0]            alloc_opcode;
  logic [PREG_W-1:0]           alloc_old_preg;
  logic [PREG_W-1:0]           alloc_curr_preg;
  logic [IDX_W-1:0]            alloc_idx;
  logic [WB_PORTS-1:0]         wb_valid;
  logic [WB_PORTS*IDX_W-1:0]   wb_idx;
  logic [WB_PORTS*DATA_W-1:0]  wb_value;
  logic [WB_PORTS*DATA_W-1:0]  wb_rs2_value;
  logic                        retire_en;
  logic [RETIRE_W-1:0]         retire_valid;
  logic [RETIRE_W*PREG_W-1:0]  retire_old_preg;
  logic [RETIRE_W*PREG_W-1:0]  retire_curr_preg;
  logic [RETIRE_W*OPC_W-1:0]   retire_opcode;
  logic [RETIRE_W*DATA_W-1:0]  retire_value;
  logic [RETIRE_W*DATA_W-1:0]  retire_rs2_value;
  logic [IDX_W:0]              count;
  logic                        empty;

  rob_buffer #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .PREG_W(PREG_W), .OPC_W(OPC_W),
    .WB_PORTS(WB_PORTS), .RETIRE_W(RETIRE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_opcode(alloc_opcode), .alloc_old_preg(alloc_old_preg),
    .alloc_curr_preg(alloc_curr_preg), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value),
    .wb_rs2_value(wb_rs2_value), .retire_en(retire_en),
    .retire_valid(retire_valid), .retire_old_preg(retire_old_preg),
    .retire_curr_preg(retire_curr_preg), .retire_opcode(retire_opcode),
    .retire_value(retire_value), .retire_rs2_value(retire_rs2_value),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the occupied entries in program order, head first.
  typedef struct {
    int                idx;
    bit                comp;
    logic [OPC_W-1:0]  opc;
    logic [PREG_W-1:0] oldp;
    logic [PREG_W-1:0] currp;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] rs2;
  } ent_t;

  ent_t mq[$];
  int   m_head;

  function automatic int m_nret();
    int n;
    n = 0;
    if (!retire_en || flush) return 0;
    while (n < RETIRE_W && n < mq.size() && mq[n].comp) n++;
    return n;
  endfunction

  task automatic idle();
    alloc_valid     = 1'b0;
    alloc_opcode    = '0;
    alloc_old_preg  = '0;
    alloc_curr_preg = '0;
    wb_valid        = '0;
    wb_idx          = '0;
    wb_value        = '0;
    wb_rs2_value    = '0;
    retire_en       = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic set_wb(input int p, input int idx, input logic [DATA_W-1:0] v,
                        input logic [DATA_W-1:0] r);
    wb_valid[p]                    = 1'b1;
    wb_idx[p*IDX_W +: IDX_W]       = IDX_W'(idx);
    wb_value[p*DATA_W +: DATA_W]   = v;
    wb_rs2_value[p*DATA_W +: DATA_W] = r;
  endtask

  task automatic set_alloc(input int curr);
    alloc_valid     = 1'b1;
    alloc_opcode    = OPC_W'($urandom);
    alloc_old_preg  = PREG_W'($urandom);
    alloc_curr_preg = PREG_W'(curr);
  endtask

  // One clock: inputs already driven at the negedge; check outputs, then
  // advance the model with the same inputs across the rising edge.
  task automatic step();
    int   n;
    int   tail_exp;
    bit   fire;
    int   widx;
    ent_t e;
    #1;
    n        = m_nret();
    tail_exp = (m_head + mq.size()) % DEPTH;
    check("count", count, mq.size());
    check("empty", empty, mq.size() == 0);
    check("alloc_ready", alloc_ready, mq.size() != DEPTH);
    check("alloc_idx", alloc_idx, tail_exp);
    check("retire_valid", retire_valid, (1 << n) - 1);
    for (int k = 0; k < n; k++) begin
      check("ret_value", retire_value[k*DATA_W +: DATA_W], mq[k].val);
      check("ret_rs2", retire_rs2_value[k*DATA_W +: DATA_W], mq[k].rs2);
      check("ret_old", retire_old_preg[k*PREG_W +: PREG_W], mq[k].oldp);
      check("ret_curr", retire_curr_preg[k*PREG_W +: PREG_W], mq[k].currp);
      check("ret_opc", retire_opcode[k*OPC_W +: OPC_W], mq[k].opc);
    end
    fire = alloc_valid && (mq.size() != DEPTH);
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_head = 0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p]) begin
          widx = int'(wb_idx[p*IDX_W +: IDX_W]);
          for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].idx == widx) begin
              mq[i].comp = 1'b1;
              mq[i].val  = wb_value[p*DATA_W +: DATA_W];
              mq[i].rs2  = wb_rs2_value[p*DATA_W +: DATA_W];
            end
          end
        end
      end
      repeat (n) void'(mq.pop_front());
      m_head = (m_head + n) % DEPTH;
      if (fire) begin
        e.idx = tail_exp; e.comp = 1'b0; e.opc = alloc_opcode;
        e.oldp = alloc_old_preg; e.currp = alloc_curr_preg;
        e.val = '0; e.rs2 = '0;
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (mq.size() > 0 && guard < 200) begin
      idle();
      retire_en = 1'b1;
      set_wb(0, mq[0].idx, DATA_W'($urandom), DATA_W'($urandom));
      if (mq.size() > 1) set_wb(1, mq[1].idx, DATA_W'($urandom), DATA_W'($urandom));
      step();
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n  = 1'b0;
    m_head = 0;
    retire_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_ready", alloc_ready, 1);
    check("rst_rvalid", retire_valid, 0);
    check("rst_idx", alloc_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Three allocations, indices 0..2
    for (int i = 0; i < 3; i++) begin
      idle();
      set_alloc(33 + i);
      #1 check("tp_alloc_idx", alloc_idx, i);
      step();
    end
    idle();
    #1 check("tp_count3", count, 3);
    check("tp_rv00", retire_valid, 0);

    // Complete idx2 and idx0; idx1 still blocks idx2
    idle();
    retire_en = 1'b1;
    set_wb(0, 2, 32'hA, 32'h1A);
    set_wb(1, 0, 32'hC, 32'h1C);
    step();
    idle();
    retire_en = 1'b1;
    set_wb(0, 1, 32'h11, 32'h111);
    set_wb(1, 1, 32'h22, 32'h222);
    #1 check("tp_rv01", retire_valid, 2'b01);
    check("tp_val_c", retire_value[DATA_W-1:0], 32'hC);
    check("tp_curr33", retire_curr_preg[PREG_W-1:0], 33);
    step();
    idle();
    retire_en = 1'b1;
    #1 check("tp_count2", count, 2);
    check("tp_rv11", retire_valid, 2'b11);
    check("tp_port_prio", retire_value[DATA_W-1:0], 32'h22);
    check("tp_val_a", retire_value[2*DATA_W-1:DATA_W], 32'hA);
    step();
    idle();
    #1 check("tp_empty", empty, 1);

    // Writeback to free slot 5 while empty must leave it incomplete
    idle();
    set_wb(0, 5, 32'hDEAD, 32'hBEEF);
    step();
    for (int i = 0; i < 3; i++) begin
      idle();
      set_alloc(40 + i);
      step();
    end
    idle();
    retire_en = 1'b1;
    set_wb(0, 3, 32'h3, 32'h3);
    set_wb(1, 4, 32'h4, 32'h4);
    step();
    idle();
    retire_en = 1'b1;
    step();
    idle();
    retire_en = 1'b1;
    #1 check("tp_free5_head", alloc_idx, 6);
    check("tp_free5_rv", retire_valid, 0);
    step();
    drain();

    // Fill to capacity; tail wraps through 31 -> 0
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      set_alloc(i);
      step();
    end
    idle();
    set_alloc(63);
    #1 check("tp_full_ready", alloc_ready, 0);
    step();
    idle();
    #1 check("tp_full_count", count, DEPTH);
    set_alloc(62);
    set_wb(0, mq[0].idx, 32'h55, 32'h66);
    set_wb(1, mq[1].idx, 32'h77, 32'h88);
    step();
    idle();
    set_alloc(61);
    retire_en = 1'b1;
    #1 check("tp_full_rv", retire_valid, 2'b11);
    step();
    idle();
    #1 check("tp_count30", count, DEPTH - 2);
    drain();

`ifdef ROB_FLUSH_EN
    for (int i = 0; i < 10; i++) begin
      idle();
      set_alloc(i);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      set_wb(0, mq[2*i].idx, DATA_W'($urandom), DATA_W'($urandom));
      set_wb(1, mq[2*i+1].idx, DATA_W'($urandom), DATA_W'($urandom));
      step();
    end
    idle();
    flush = 1'b1;
    retire_en = 1'b1;
    set_alloc(9);
    #1 check("tp_flush_rv", retire_valid, 0);
    step();
    idle();
    #1 check("tp_flush_count", count, 0);
    check("tp_flush_idx", alloc_idx, 0);
`endif

    // Randomized traffic with one asynchronous reset mid-run
    for (int cyc = 0; cyc < 1500; cyc++) begin
      idle();
      if ($urandom_range(0, 9) < ((cyc < 700) ? 8 : 5)) set_alloc(int'($urandom_range(0, 63)));
      retire_en = ($urandom_range(0, 9) < 7);
      for (int p = 0; p < WB_PORTS; p++) begin
        if ($urandom_range(0, 9) < 5) begin
          if (mq.size() > 0 && $urandom_range(0, 9) < 8)
            set_wb(p, mq[$urandom_range(0, mq.size() - 1)].idx, DATA_W'($urandom), DATA_W'($urandom));
          else
            set_wb(p, int'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom), DATA_W'($urandom));
        end
      end
`ifdef ROB_FLUSH_EN
      flush = ($urandom_range(0, 59) == 0);
`endif
      if (cyc == 900) begin
        retire_en = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("mid_rst_count", count, 0);
        check("mid_rst_rv", retire_valid, 0);
        check("mid_rst_empty", empty, 1);
        mq.delete();
        m_head = 0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_buffer.md
Name: rob_buffer

Overview:
Parametrised reorder buffer: a circular queue of ROB entries carrying old/current physical dest regs, opcode, result value and rs2 value. It allocates one entry per cycle at dispatch and accepts completions from WB_PORTS writeback ports by ROB index. It retires up to RETIRE_W consecutive completed entries per cycle, in order from the head. It sits between dispatch/rename and the commit/free-list logic, and generalises the fixed 32-entry ROB entry format to configurable depth, width, writeback ports and retire width.

Parameters:
DEPTH, 32, number of entries; power of 2, >=4
DATA_W, 32, width of rd_value / rs2_value
PREG_W, 6, physical register index width
OPC_W, 7, opcode width
WB_PORTS, 2, number of writeback (completion) ports
RETIRE_W, 2, max entries retired per cycle, 1..DEPTH
(derived) IDX_W = $clog2(DEPTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
alloc_valid  in  1  dispatch requests an entry
alloc_ready  out  1  entry available (count != DEPTH)
alloc_opcode  in  OPC_W  opcode of allocated instr
alloc_old_preg  in  PREG_W  previous mapping of rd
alloc_curr_preg  in  PREG_W  new mapping of rd
alloc_idx  out  IDX_W  ROB index granted (= tail)
wb_valid  in  WB_PORTS  per-port completion strobe
wb_idx  in  WB_PORTS*IDX_W  per-port ROB index
wb_value  in  WB_PORTS*DATA_W  per-port result
wb_rs2_value  in  WB_PORTS*DATA_W  per-port store data
retire_en  in  1  commit stage accepts retirements this cycle
retire_valid  out  RETIRE_W  slot k retires this cycle (thermometer, bit0 first)
retire_old_preg  out  RETIRE_W*PREG_W  per slot
retire_curr_preg  out  RETIRE_W*PREG_W  per slot
retire_opcode  out  RETIRE_W*OPC_W  per slot
retire_value  out  RETIRE_W*DATA_W  per slot
retire_rs2_value  out  RETIRE_W*DATA_W  per slot
count  out  IDX_W+1  occupied entries
empty  out  1  count == 0
flush  in  1  pipeline flush (present only with ROB_FLUSH_EN)

Behaviour:
- Reset (async, rst_n=0): all in_use/is_complete cleared; head=tail=0; count=0; empty=1; alloc_ready=1; retire_valid=0. Payload fields need not be reset. Reset mid-operation drops all entries immediately.
- Alloc: on clk edge with alloc_valid&alloc_ready, entry[tail] gets in_use=1, is_complete=0 and the alloc fields; tail=tail+1 mod DEPTH. alloc_idx=tail is combinational. alloc_valid while full is ignored. No same-cycle reuse of a slot freed by retire: alloc_ready depends only on registered count.
- Writeback: wb_valid[p] with entry[wb_idx[p]].in_use=1 sets is_complete=1 and stores wb_value/wb_rs2_value at the edge. Writeback to an entry that is not in_use, including the slot being allocated this cycle, is ignored. If two ports target the same index in one cycle, the highest port number wins. Writeback to an already-complete entry overwrites its values.
- Retire (combinational from registered state): retire_valid[k]=retire_en & all entries head..head+k in_use & is_complete, so valid bits are contiguous from bit0. Slot k outputs entry[head+k mod DEPTH]. Payload is don't-care when valid=0. At the edge, the n retired entries clear in_use/is_complete and head+=n mod DEPTH.
- Latency: a writeback in cycle N is retire-visible in cycle N+1. There is no same-cycle bypass.
- count_next = count + alloc_fire - n_retired. Simultaneous alloc and retire are both legal. Pointers wrap modulo DEPTH. Full versus empty is resolved by count, not by pointer equality.
- Entries beyond an incomplete entry never retire, even if they are complete.

Optional Feature:
ROB_FLUSH_EN. When defined, the flush port exists. flush=1 at an edge clears all in_use/is_complete and sets head=tail=count=0. Alloc, writeback and retire in that cycle are discarded, and retire_valid is forced to 0 while flush=1. When not defined, the port is absent and entries leave only by retire or reset.

Test Plan:
- Reset, then alloc 3 entries (curr_preg 33,34,35) -> alloc_idx 0,1,2; count=3; retire_valid=00.
- WB idx2 then idx0 (values 0xA,0xC), retire_en=1 -> next cycle retire_valid=01 with value 0xC; idx1 incomplete blocks idx2; count=2.
- WB idx1 on port0 and idx1 on port1 same cycle (0x11, 0x22) -> idx1 value 0x22; next cycle retire_valid=11 retiring idx1, idx2; empty=1.
- Fill 32 entries -> alloc_ready=0; 33rd alloc ignored. Complete and retire 2 while allocating -> count stays 32-2+0=30. Tail wraps 31->0.
- WB to a free index 5 while empty -> no state change; later alloc at idx5 arrives with is_complete=0.
- With ROB_FLUSH_EN: 10 entries, 4 complete, flush plus alloc_valid in the same cycle -> retire_valid=0, next cycle count=0, alloc_idx=0.
